// File: rtl/grid_scanner_if.sv
// grid_scanner_if: bus between the Life engine/board side and the grid scanner.
// Optional live_count signal present when GRID_SCANNER_POPCOUNT_EN is defined.
interface grid_scanner_if;
    logic        en;
    logic [63:0] grid_in;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;
    logic        gen_step;
`ifdef GRID_SCANNER_POPCOUNT_EN
    logic [6:0]  live_count;

    modport master (
        output en, grid_in,
        input  row_sel, col_data, frame_done, gen_step, live_count
    );
    modport slave (
        input  en, grid_in,
        output row_sel, col_data, frame_done, gen_step, live_count
    );
`else
    modport master (
        output en, grid_in,
        input  row_sel, col_data, frame_done, gen_step
    );
    modport slave (
        input  en, grid_in,
        output row_sel, col_data, frame_done, gen_step
    );
`endif
endinterface

// File: rtl/grid_scanner.sv
// grid_scanner: snapshots a 64-bit Life grid per frame and row-multiplexes it
// onto an 8x8 LED matrix. Optional macro GRID_SCANNER_POPCOUNT_EN adds live_count.
module grid_scanner #(
    parameter int ROW_CYCLES     = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter int FRAMES_PER_GEN = 30
) (
    input  logic          clk,
    input  logic          flopreset,
    grid_scanner_if.slave bus
);

    localparam int CMAX = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
    localparam int FW   = (FRAMES_PER_GEN > 1) ? $clog2(FRAMES_PER_GEN) : 1;

    localparam logic [CW-1:0] ROW_LAST   = CW'(ROW_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FRAMES_PER_GEN - 1);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // With no blanking configured a row is entered directly in SHOW.
    localparam state_t ROW_ENTRY = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t        r_state,      w_state;
    logic [63:0]   r_snapshot,   w_snapshot;
    logic [2:0]    r_row_idx,    w_row_idx;
    logic [CW-1:0] r_cycle_cnt,  w_cycle_cnt;
    logic [FW-1:0] r_frame_cnt,  w_frame_cnt;
    logic          r_first,      w_first;
    logic [7:0]    r_row_sel,    w_row_sel;
    logic [7:0]    r_col_data,   w_col_data;
    logic          r_frame_done, w_frame_done;
    logic          r_gen_step,   w_gen_step;

    // Next-state and next-output logic; outputs are derived from the next state
    // so the registered drive lines up with the state they belong to.
    always_comb begin
        w_state     = r_state;
        w_snapshot  = r_snapshot;
        w_row_idx   = r_row_idx;
        w_cycle_cnt = r_cycle_cnt;
        w_frame_cnt = r_frame_cnt;
        w_first     = r_first;

        if (!bus.en) begin
            w_state     = LOAD;
            w_row_idx   = '0;
            w_cycle_cnt = '0;
            w_frame_cnt = '0;
            w_first     = 1'b1;
        end else begin
            unique case (r_state)
                LOAD: begin
                    w_snapshot  = bus.grid_in;
                    w_row_idx   = '0;
                    w_cycle_cnt = '0;
                    w_first     = 1'b0;
                    // The first LOAD after reset/enable closes no frame.
                    if (!r_first) begin
                        if (r_frame_cnt == FRAME_LAST)
                            w_frame_cnt = '0;
                        else
                            w_frame_cnt = r_frame_cnt + 1'b1;
                    end
                    w_state = ROW_ENTRY;
                end
                BLANK: begin
                    if (r_cycle_cnt == BLANK_LAST) begin
                        w_cycle_cnt = '0;
                        w_state     = SHOW;
                    end else begin
                        w_cycle_cnt = r_cycle_cnt + 1'b1;
                    end
                end
                SHOW: begin
                    if (r_cycle_cnt == ROW_LAST) begin
                        w_cycle_cnt = '0;
                        if (r_row_idx == 3'd7) begin
                            w_state = LOAD;
                        end else begin
                            w_row_idx = r_row_idx + 3'd1;
                            w_state   = ROW_ENTRY;
                        end
                    end else begin
                        w_cycle_cnt = r_cycle_cnt + 1'b1;
                    end
                end
                default: w_state = LOAD;
            endcase
        end

        w_row_sel    = '0;
        w_col_data   = '0;
        w_frame_done = 1'b0;
        w_gen_step   = 1'b0;
        if (w_state == SHOW) begin
            w_row_sel  = 8'h01 << w_row_idx;
            w_col_data = w_snapshot[{w_row_idx, 3'b000} +: 8];
        end
        if ((w_state == LOAD) && !w_first) begin
            w_frame_done = 1'b1;
            w_gen_step   = (w_frame_cnt == FRAME_LAST);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (flopreset) begin
            r_state      <= LOAD;
            r_snapshot   <= '0;
            r_row_idx    <= '0;
            r_cycle_cnt  <= '0;
            r_frame_cnt  <= '0;
            r_first      <= 1'b1;
            r_row_sel    <= '0;
            r_col_data   <= '0;
            r_frame_done <= 1'b0;
            r_gen_step   <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_snapshot   <= w_snapshot;
            r_row_idx    <= w_row_idx;
            r_cycle_cnt  <= w_cycle_cnt;
            r_frame_cnt  <= w_frame_cnt;
            r_first      <= w_first;
            r_row_sel    <= w_row_sel;
            r_col_data   <= w_col_data;
            r_frame_done <= w_frame_done;
            r_gen_step   <= w_gen_step;
        end
    end

    assign bus.row_sel    = r_row_sel;
    assign bus.col_data   = r_col_data;
    assign bus.frame_done = r_frame_done;
    assign bus.gen_step   = r_gen_step;

`ifdef GRID_SCANNER_POPCOUNT_EN
    logic [6:0] r_live_count;

    function automatic logic [6:0] popcnt64(input logic [63:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < 64; i++)
            n = n + {6'd0, v[i]};
        return n;
    endfunction

    // Count is captured alongside the snapshot, so it tracks the shown grid.
    always_ff @(posedge clk) begin
        if (flopreset)
            r_live_count <= '0;
        else if ((r_state == LOAD) && bus.en)
            r_live_count <= popcnt64(bus.grid_in);
    end

    assign bus.live_count = r_live_count;
`endif

endmodule

// File: tb/tb_grid_scanner.sv
// tb_grid_scanner: directed bench for grid_scanner with a 25-clock frame
// (ROW_CYCLES=2, BLANK_CYCLES=1, FRAMES_PER_GEN=2).
module tb_grid_scanner;

    localparam logic [63:0] DIAG = 64'h8040201008040201;
    localparam logic [63:0] ONES = 64'hFFFFFFFF_FFFFFFFF;

    logic clk = 1'b0;
    logic flopreset;
    int   n_assert = 0;
    int   n_fail   = 0;

    grid_scanner_if bus();

    grid_scanner #(
        .ROW_CYCLES    (2),
        .BLANK_CYCLES  (1),
        .FRAMES_PER_GEN(2)
    ) dut (
        .clk      (clk),
        .flopreset(flopreset),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [7:0] rs, input logic [7:0] cd,
                            input logic fd, input logic gs);
        chk({tag, ".row_sel"},    {56'd0, bus.row_sel},    {56'd0, rs});
        chk({tag, ".col_data"},   {56'd0, bus.col_data},   {56'd0, cd});
        chk({tag, ".frame_done"}, {63'd0, bus.frame_done}, {63'd0, fd});
        chk({tag, ".gen_step"},   {63'd0, bus.gen_step},   {63'd0, gs});
    endtask

    // Phase p in 1..24 of a frame: (p-1)/3 is the row, (p-1)%3==0 is blanking.
    task automatic chk_phase(input int p, input logic [63:0] snap);
        int         k;
        int         m;
        logic [7:0] rs;
        logic [7:0] cd;
        k  = (p - 1) / 3;
        m  = (p - 1) % 3;
        rs = (m == 0) ? 8'h00 : (8'h01 << k);
        cd = (m == 0) ? 8'h00 : snap[8*k +: 8];
        chk_outs($sformatf("ph%0d", p), rs, cd, 1'b0, 1'b0);
    endtask

    task automatic frame_body(input logic [63:0] snap);
        for (int p = 1; p <= 24; p++) begin
            step();
            chk_phase(p, snap);
        end
    endtask

    task automatic load_check(input string tag, input logic fd, input logic gs);
        step();
        chk_outs(tag, 8'h00, 8'h00, fd, gs);
    endtask

    initial begin
        flopreset   = 1'b1;
        bus.en      = 1'b1;
        bus.grid_in = DIAG;
        step();
        step();
        chk_outs("reset", 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef GRID_SCANNER_POPCOUNT_EN
        chk("reset.live_count", {57'd0, bus.live_count}, 64'd0);
`endif
        flopreset = 1'b0;

        // Diagonal grid, five frame boundaries' worth of pulses
        frame_body(DIAG);
        load_check("ld25", 1'b1, 1'b0);
        frame_body(DIAG);
        load_check("ld50", 1'b1, 1'b1);
        frame_body(DIAG);
        load_check("ld75", 1'b1, 1'b0);
        frame_body(DIAG);
        load_check("ld100", 1'b1, 1'b1);

        // grid_in change mid-frame is not visible until the next LOAD
        bus.grid_in = ONES;
        for (int p = 1; p <= 24; p++) begin
            step();
            chk_phase(p, ONES);
            if (p == 12)
                bus.grid_in = 64'd0;
        end
        load_check("ld125", 1'b1, 1'b0);
        frame_body(64'd0);
        load_check("ld150", 1'b1, 1'b1);

        // Drop enable for one clock while row 4 is lit
        bus.grid_in = DIAG;
        for (int p = 1; p <= 14; p++) begin
            step();
            chk_phase(p, DIAG);
        end
        bus.en = 1'b0;
        step();
        chk_outs("en_off", 8'h00, 8'h00, 1'b0, 1'b0);
        bus.en = 1'b1;
        frame_body(DIAG);
        load_check("en_f1", 1'b1, 1'b0);
        frame_body(DIAG);
        load_check("en_f2", 1'b1, 1'b1);

        // Reset while row 6 is lit
        for (int p = 1; p <= 20; p++) begin
            step();
            chk_phase(p, DIAG);
        end
        flopreset = 1'b1;
        step();
        chk_outs("rst_mid", 8'h00, 8'h00, 1'b0, 1'b0);
`ifdef GRID_SCANNER_POPCOUNT_EN
        chk("rst_mid.live_count", {57'd0, bus.live_count}, 64'd0);
`endif
        flopreset = 1'b0;
        frame_body(DIAG);
        load_check("rst_f1", 1'b1, 1'b0);

`ifdef GRID_SCANNER_POPCOUNT_EN
        // live_count follows the snapshot one clock after each LOAD
        bus.grid_in = 64'h00000000_0000FFFF;
        for (int p = 1; p <= 24; p++) begin
            step();
            chk_phase(p, 64'h00000000_0000FFFF);
            if (p == 1)
                chk("pop16", {57'd0, bus.live_count}, 64'd16);
        end
        bus.grid_in = ONES;
        load_check("pop_ld", 1'b1, 1'b1);
        step();
        chk("pop64", {57'd0, bus.live_count}, 64'd64);
        chk_phase(1, ONES);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/grid_scanner.md
Name: grid_scanner

Overview:
- Consumer of the 64-bit Life grid register output: snapshots the grid once per frame and row-multiplexes it onto an 8x8 LED matrix (one-hot row select plus 8 column lines).
- Sits between the Life engine's grid flop output and the board pins.
- Issues a one-cycle gen_step pulse every FRAMES_PER_GEN frames, used as the engine's evolve enable, so generations advance only on frame boundaries and the display never tears.

Parameters:
ROW_CYCLES, 1000, clocks each row is lit (>=1)
BLANK_CYCLES, 16, all-off clocks before each row (>=0; 0 = no blanking)
FRAMES_PER_GEN, 30, frames displayed per generation (>=1)

Ports:
clk  input  1  system clock
flopreset  input  1  synchronous, active-high reset
en  input  1  scan enable; 0 blanks the matrix and holds the FSM in LOAD
grid_in  input  64  live grid; bit 8*r+c = row r, column c
row_sel  output  8  one-hot active-high row drive; bit r = row r
col_data  output  8  column drive for the lit row; bit c = grid[8*r+c]
frame_done  output  1  one-cycle pulse at each completed frame
gen_step  output  1  one-cycle pulse every FRAMES_PER_GEN completed frames

Behaviour:
- All outputs registered. Reset is synchronous, active-high, and takes effect at the next edge even mid-frame.
- Reset state: state=LOAD, snapshot=0, row_idx=0, cycle_cnt=0, frame_cnt=0, first=1, row_sel=0, col_data=0, frame_done=0, gen_step=0.
- Counter widths: $clog2 of each parameter, minimum 1 bit.
- LOAD (exactly 1 cycle):
  - snapshot<=grid_in; row_idx<=0; cycle_cnt<=0.
  - Next state: BLANK, or SHOW if BLANK_CYCLES==0.
  - frame_done=1 in this cycle unless first=1; first<=0.
  - gen_step=1 in this cycle when frame_done=1 and frame_cnt had reached FRAMES_PER_GEN-1; frame_cnt then wraps to 0. Otherwise frame_cnt increments on each frame_done.
- BLANK: row_sel=0, col_data=0 for BLANK_CYCLES cycles, then SHOW.
- SHOW:
  - row_sel = 1<<row_idx, col_data = snapshot[8*row_idx +: 8] for ROW_CYCLES cycles.
  - At the end of the row: if row_idx==7, go to LOAD; else row_idx++ and go to BLANK (or SHOW if BLANK_CYCLES==0).
- Frame length: 8*(BLANK_CYCLES+ROW_CYCLES)+1 clocks. Steady-state gen_step period: FRAMES_PER_GEN frames.
- grid_in latency: a change is shown starting from the first row after the next LOAD. grid_in is ignored outside LOAD.
- en=0 in any state:
  - Next cycle: state=LOAD, row_sel=0, col_data=0.
  - frame_cnt=0, first=1, no pulses.
  - Scanning resumes in the cycle en returns to 1, starting with a LOAD that emits no frame_done.
- row_sel is never multi-hot and is 0 during LOAD and BLANK.
- A grid of all zeros is still scanned normally (col_data=0).

Optional Feature:
- Macro: GRID_SCANNER_POPCOUNT_EN.
- Defined: adds output live_count [6:0], registered, equal to the popcount of snapshot. It updates in the cycle after each LOAD and resets to 0.
- Not defined: the port is absent and no popcount logic is built. All other behaviour is identical.

Test Plan:
All scenarios use ROW_CYCLES=2, BLANK_CYCLES=1, FRAMES_PER_GEN=2, giving a 25-clock frame.
1. Reset, en=1, grid_in=64'h8040201008040201 -> after LOAD+BLANK, row_sel=8'h01/col_data=8'h01 for 2 clocks. Each later row r shows row_sel=col_data=1<<r. row_sel is 0 during every BLANK.
2. Run 5 frames -> frame_done pulses at clocks 25, 50, 75, 100 after the first LOAD; none at the first LOAD. gen_step pulses at 50 and 100 only.
3. Change grid_in mid-frame from all-ones to 0 -> rows of the current frame keep col_data=8'hFF. The next frame shows col_data=0.
4. Drop en for 1 clock during row 4 -> next clock row_sel=0. Resume from LOAD with no frame_done. gen_step occurs only after 2 further full frames.
5. Assert flopreset during SHOW of row 6 -> next clock all outputs 0 and state=LOAD. The first post-reset LOAD produces no pulse.
6. With GRID_SCANNER_POPCOUNT_EN and grid_in=64'h00000000_0000FFFF -> live_count=16 one clock after LOAD. Set grid_in to all ones -> live_count=64 after the next LOAD.
